// File: rtl/usb_rst_sequencer.sv
// USB host controller reset sequencer: timed reset pulse, settle window,
// readiness flag and an Avalon-MM status/control/counter slave.
module usb_rst_sequencer #(
  parameter int unsigned RST_CYCLES    = 5000,
  parameter int unsigned SETTLE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        usb_ready
);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [19:0] RST_LAST = 20'(RST_CYCLES - 1);
  localparam logic [19:0] SET_LAST = 20'(SETTLE_CYCLES - 1);

  state_t      state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [15:0] reset_count;
  logic        done;
  logic        wr, wr_ctrl, wr_cnt;
  logic        trig, count_inc, done_set;
  logic        unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign wr_cnt    = wr & (address == 2'd1);
  assign trig      = rst_req | (wr_ctrl & writedata[0]);
  assign unused_wd = ^{writedata[31:3], writedata[1]};

  // A trigger held in ASSERT blocks the exit, so the pulse is max(RST, N)
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    count_inc = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      ASSERT: begin
        if (cnt != RST_LAST)
          cnt_nx = cnt + 20'd1;
        if (!trig && cnt == RST_LAST) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
      end
      SETTLE: begin
        if (trig) begin
          state_nx  = ASSERT;
          cnt_nx    = '0;
          count_inc = 1'b1;
        end else if (cnt == SET_LAST) begin
          state_nx = READY;
          cnt_nx   = '0;
          done_set = 1'b1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      READY: begin
        if (trig) begin
          state_nx  = ASSERT;
          cnt_nx    = '0;
          count_inc = 1'b1;
        end
      end
      default: begin
        state_nx = ASSERT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ASSERT;
      cnt       <= '0;
      usb_rst_n <= 1'b0;
      usb_ready <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      usb_rst_n <= (state_nx != ASSERT);
      usb_ready <= (state_nx == READY);
    end
  end

  // Set beats clear for done; clear beats increment for the counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done        <= 1'b0;
      reset_count <= '0;
    end else begin
      if (done_set)
        done <= 1'b1;
      else if (wr_ctrl && writedata[2])
        done <= 1'b0;
      if (wr_cnt)
        reset_count <= '0;
      else if (count_inc)
        reset_count <= reset_count + 16'd1;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == 2'd0):
        readdata = {28'd0, rst_req, done, (state != READY), usb_ready};
      (address == 2'd1):
        readdata = {16'd0, reset_count};
      default:
        readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Scoreboard bench for usb_rst_sequencer: timestamp-based reference model,
// directed scenarios followed by randomized PIO and Avalon traffic.
module tb_usb_rst_sequencer;

  localparam int RST = 4;
  localparam int SET = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rst_req = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        usb_ready;

  always #5 clk = ~clk;

  usb_rst_sequencer #(
    .RST_CYCLES(RST),
    .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rst_req(rst_req),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .usb_rst_n(usb_rst_n),
    .usb_ready(usb_ready)
  );

  typedef struct packed {
    logic        rn;
    logic        rd;
    logic [31:0] rdat;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  // Model: edge index k, reset low since edge m_s, settle began at m_set
  int          k = 0;
  int          m_s = 0;
  int          m_set = 0;
  bit          m_low = 1'b1;
  bit          m_rdy = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_low  = 1'b1;
    m_rdy  = 1'b0;
    m_done = 1'b0;
    m_cnt  = '0;
    m_s    = k;
  endtask

  // Called at a negedge: drive inputs, predict the next edge, push, advance
  task automatic step(input logic rq, input logic cs, input logic wn,
                      input logic [1:0] a, input logic [31:0] wd);
    bit   wr, trig, inc, setd;
    exp_t e;
    rst_req    = rq;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    wr   = cs && !wn;
    trig = rq || (wr && a == 2'd0 && wd[0]);
    inc  = 1'b0;
    setd = 1'b0;
    k++;
    if (m_low) begin
      if (k - m_s >= RST && !trig) begin
        m_low = 1'b0;
        m_set = k;
      end
    end else if (trig) begin
      m_low = 1'b1;
      m_rdy = 1'b0;
      m_s   = k;
      inc   = 1'b1;
    end else if (!m_rdy && k - m_set >= SET) begin
      m_rdy = 1'b1;
      setd  = 1'b1;
    end
    if (setd)
      m_done = 1'b1;
    else if (wr && a == 2'd0 && wd[2])
      m_done = 1'b0;
    if (wr && a == 2'd1)
      m_cnt = '0;
    else if (inc)
      m_cnt = m_cnt + 16'd1;
    e.rn = !m_low;
    e.rd = m_rdy;
    case (a)
      2'd0:    e.rdat = {28'd0, rq, m_done, !m_rdy, m_rdy};
      2'd1:    e.rdat = {16'd0, m_cnt};
      default: e.rdat = '0;
    endcase
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("usb_rst_n", {31'd0, usb_rst_n}, {31'd0, e.rn});
        chk("usb_ready", {31'd0, usb_ready}, {31'd0, e.rd});
        chk("readdata", readdata, e.rdat);
      end
    end
  end

  initial begin : stim
    logic        rq, cs, wn;
    logic [1:0]  a;
    logic [31:0] wd;
    int          burst;
    burst = 0;
    #1;
    chk("rst_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
    chk("rst_usb_ready", {31'd0, usb_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    idle(12, 2'd0);
    idle(1, 2'd1);

    step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
    idle(12, 2'd1);

    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
    idle(12, 2'd1);

    step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
    idle(6, 2'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
    idle(12, 2'd1);

    wr_reg(2'd0, 32'h1);
    idle(12, 2'd0);
    wr_reg(2'd0, 32'h4);
    idle(2, 2'd0);

    wr_reg(2'd0, 32'h1);
    idle(9, 2'd0);
    wr_reg(2'd0, 32'h4);
    idle(2, 2'd0);

    wr_reg(2'd1, 32'h0);
    idle(1, 2'd1);
    step(1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
    idle(12, 2'd1);

    step(1'b1, 1'b0, 1'b1, 2'd1, 32'd0);
    idle(6, 2'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
    chk("async_usb_ready", {31'd0, usb_ready}, 32'd0);
    chk("async_count", readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(12, 2'd0);

    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 99) < 3)
        burst = $urandom_range(1, 25);
      rq = (burst > 0);
      if (burst > 0)
        burst--;
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 9) != 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if ($urandom_range(0, 3) != 0)
        wd[0] = 1'b0;
      step(rq, cs, wn, a, wd);
    end
    idle(12, 2'd0);

    chk("drain", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
